// File: rtl/alu_red_pkg.sv
// Shared types for the primary/spare ALU redundancy sequencer.
package alu_red_pkg;

  localparam int unsigned CTRL_W = 3;

  // IDLE must stay 2'b00: the pipeline derives its stall as state != 2'b00.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    P3   = 2'b11
  } state_e;

  localparam logic UNIT_P = 1'b0;
  localparam logic UNIT_S = 1'b1;

  // Which ALU supplies the result for the pass currently in flight.
  function automatic logic pass_unit(input state_e st, input logic spare_active,
                                     input logic spare_bad);
    if (spare_active) begin
      return UNIT_S;
    end else if (spare_bad) begin
      return UNIT_P;
    end else if (st == P2) begin
      return UNIT_S;
    end else begin
      return UNIT_P;
    end
  endfunction

endpackage

// File: rtl/redundant_vote.sv
// Combinational 3-input majority voter over the three pass results.
module redundant_vote #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] winner,
  output logic             match12,
  output logic             match13,
  output logic             match23,
  output logic             all_differ
);

  // Pairwise compares; with no majority the latest pass wins.
  always_comb begin
    match12    = (r1 == r2);
    match13    = (r1 == r3);
    match23    = (r2 == r3);
    all_differ = !(match12 || match13 || match23);
    if (match12 || match13) begin
      winner = r1;
    end else if (match23) begin
      winner = r2;
    end else begin
      winner = r3;
    end
  end

endmodule

// File: rtl/alu_redundancy_sequencer.sv
// Time-redundant primary/spare ALU sequencer with voting and fault tracking.
module alu_redundancy_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CTRL_W      = alu_red_pkg::CTRL_W,
  parameter int unsigned FAULT_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic [CTRL_W-1:0] op_ctrl,
  input  logic [WIDTH-1:0]  res_p,
  input  logic [WIDTH-1:0]  res_s,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              fault_detected,
  output logic              uncorrectable,
  output logic              spare_active,
  output logic              spare_bad,
  input  logic              clear_faults
);
  import alu_red_pkg::*;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
  logic [WIDTH-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              done_q, done_d, fault_q, fault_d, uncorr_q, uncorr_d;
  logic              spare_active_q, spare_active_d, spare_bad_q, spare_bad_d;
  logic [3:0]        cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0]  sel_res, winner;
  logic              match12, match13, match23, all_differ, normal_mode;

  redundant_vote #(
    .WIDTH(WIDTH)
  ) u_vote (
    .r1        (r1_q),
    .r2        (r2_q),
    .r3        (sel_res),
    .winner    (winner),
    .match12   (match12),
    .match13   (match13),
    .match23   (match23),
    .all_differ(all_differ)
  );

  // Next-state, pass sequencing, voting and blame bookkeeping.
  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_ctrl_d      = op_ctrl_q;
    r1_d           = r1_q;
    r2_d           = r2_q;
    result_d       = result_q;
    done_d         = 1'b0;
    fault_d        = 1'b0;
    uncorr_d       = 1'b0;
    spare_active_d = spare_active_q;
    spare_bad_d    = spare_bad_q;
    cnt_d          = cnt_q;
    cnt_inc        = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    normal_mode    = !spare_active_q && !spare_bad_q;
    sel_res        = (pass_unit(state_q, spare_active_q, spare_bad_q) == UNIT_S) ? res_s : res_p;

    unique case (state_q)
      IDLE: begin
        // Clear takes effect before a same-cycle start so that op runs in normal mode.
        if (clear_faults) begin
          spare_active_d = 1'b0;
          spare_bad_d    = 1'b0;
          cnt_d          = 4'd0;
        end
        if (start) begin
          op_a_d    = a_in;
          op_b_d    = b_in;
          op_ctrl_d = ctrl_in;
          state_d   = P1;
        end
      end
      P1: begin
        r1_d    = sel_res;
        state_d = P2;
      end
      P2: begin
        if (sel_res == r1_q) begin
          result_d = r1_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          r2_d    = sel_res;
          state_d = P3;
        end
      end
      P3: begin
        result_d = winner;
        done_d   = 1'b1;
        fault_d  = 1'b1;
        uncorr_d = all_differ;
        state_d  = IDLE;
        // Blame is only meaningful when P1/P3 and P2 ran on different units.
        if (normal_mode && !all_differ) begin
          if (match12 || match13) begin
            spare_bad_d = 1'b1;
          end else if (match23) begin
            cnt_d = cnt_inc;
            if (32'(cnt_inc) >= FAULT_LIMIT) begin
              spare_active_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_ctrl_q      <= '0;
      r1_q           <= '0;
      r2_q           <= '0;
      result_q       <= '0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
      uncorr_q       <= 1'b0;
      spare_active_q <= 1'b0;
      spare_bad_q    <= 1'b0;
      cnt_q          <= 4'd0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_ctrl_q      <= op_ctrl_d;
      r1_q           <= r1_d;
      r2_q           <= r2_d;
      result_q       <= result_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
      uncorr_q       <= uncorr_d;
      spare_active_q <= spare_active_d;
      spare_bad_q    <= spare_bad_d;
      cnt_q          <= cnt_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign op_ctrl        = op_ctrl_q;
  assign done           = done_q;
  assign result         = result_q;
  assign fault_detected = fault_q;
  assign uncorrectable  = uncorr_q;
  assign spare_active   = spare_active_q;
  assign spare_bad      = spare_bad_q;

endmodule

// File: tb/tb_alu_redundancy_sequencer.sv
// Randomised self-checking bench for alu_redundancy_sequencer against a behavioural model.
module tb_alu_redundancy_sequencer;
  localparam int unsigned W     = 32;
  localparam int unsigned CW    = 3;
  localparam int unsigned LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst, start, clear_faults;
  logic [W-1:0]  a_in, b_in, res_p, res_s, op_a, op_b, result;
  logic [CW-1:0] ctrl_in, op_ctrl;
  logic          busy, done, fault_detected, uncorrectable, spare_active, spare_bad;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the fault bookkeeping.
  bit m_sa, m_sb;
  int m_cnt;

  always #5 clk = ~clk;

  alu_redundancy_sequencer #(
    .WIDTH      (W),
    .CTRL_W     (CW),
    .FAULT_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .a_in          (a_in),
    .b_in          (b_in),
    .ctrl_in       (ctrl_in),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_ctrl       (op_ctrl),
    .res_p         (res_p),
    .res_s         (res_s),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .fault_detected(fault_detected),
    .uncorrectable (uncorrectable),
    .spare_active  (spare_active),
    .spare_bad     (spare_bad),
    .clear_faults  (clear_faults)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one operation from a negedge; pass k sees res_p=pv[k], res_s=sv[k].
  // Returns at the negedge of the done cycle so a following op is back-to-back.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                        input bit clr, input logic [31:0] p1, input logic [31:0] p2,
                        input logic [31:0] p3, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] s3);
    logic [31:0] pv[4], sv[4], v[4], exp_res;
    bit use_spare, normal, exp_fd, exp_uc, done_seen;
    int lat;
    pv[1] = p1; pv[2] = p2; pv[3] = p3;
    sv[1] = s1; sv[2] = s2; sv[3] = s3;
    if (clr) begin
      m_sa = 0; m_sb = 0; m_cnt = 0;
    end
    normal = !m_sa && !m_sb;
    for (int k = 1; k <= 3; k++) begin
      if (m_sa)      use_spare = 1;
      else if (m_sb) use_spare = 0;
      else           use_spare = (k == 2);
      v[k] = use_spare ? sv[k] : pv[k];
    end
    exp_fd = 0; exp_uc = 0;
    if (v[1] == v[2]) begin
      lat = 3; exp_res = v[1];
    end else begin
      lat = 4; exp_fd = 1;
      if (v[3] == v[1]) begin
        exp_res = v[1];
        if (normal) m_sb = 1;
      end else if (v[3] == v[2]) begin
        exp_res = v[2];
        if (normal) begin
          m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          if (m_cnt >= LIMIT) m_sa = 1;
        end
      end else begin
        exp_res = v[3]; exp_uc = 1;
      end
    end

    a_in = a; b_in = b; ctrl_in = ctrl; start = 1'b1; clear_faults = clr;
    @(posedge clk);
    #1;
    start = 1'b0; clear_faults = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 6 && !done_seen; c++) begin
      if (c <= 3) begin
        res_p = pv[c]; res_s = sv[c];
      end
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        check_val("latency", 32'(c), 32'(lat));
        check_val("result", result, exp_res);
        check_val("fault_detected", {31'b0, fault_detected}, {31'b0, exp_fd});
        check_val("uncorrectable", {31'b0, uncorrectable}, {31'b0, exp_uc});
        check_val("spare_active", {31'b0, spare_active}, {31'b0, m_sa});
        check_val("spare_bad", {31'b0, spare_bad}, {31'b0, m_sb});
        check_val("busy_at_done", {31'b0, busy}, 32'd0);
      end else begin
        check_val("busy", {31'b0, busy}, 32'd1);
        check_val("op_a", op_a, a);
        check_val("op_b", op_b, b);
        check_val("op_ctrl", {29'b0, op_ctrl}, {29'b0, ctrl});
        @(posedge clk);
        #1;
      end
    end
    if (!done_seen) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] base, pr[3], sr[3];
    rst = 1'b1; start = 1'b0; clear_faults = 1'b0;
    a_in = '0; b_in = '0; ctrl_in = '0; res_p = '0; res_s = '0;
    m_sa = 0; m_sb = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_op_a", op_a, 32'd0);
    check_val("rst_flags", {30'b0, spare_active, spare_bad}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean op, then a spare transient.
    run_op(5, 7, 3'd0, 0, 12, 12, 12, 12, 12, 12);
    run_op(5, 7, 3'd1, 0, 12, 12, 12, 12, 13, 12);
    // Primary retirement after three primary-blamed ops, then spare-only op.
    run_op(1, 2, 3'd2, 1, 99, 12, 12, 12, 12, 12);
    run_op(1, 2, 3'd2, 0, 99, 12, 12, 12, 12, 12);
    run_op(1, 2, 3'd2, 0, 99, 12, 12, 12, 12, 12);
    run_op(3, 4, 3'd3, 0, 77, 77, 77, 12, 12, 12);
    // Clear with start while retired: P2 must use the spare again.
    run_op(3, 4, 3'd4, 1, 12, 12, 12, 12, 13, 12);
    // Uncorrectable in normal mode.
    run_op(6, 6, 3'd5, 1, 1, 9, 3, 8, 2, 8);
    // Set spare_bad, then reset in the middle of a mismatching op.
    run_op(8, 9, 3'd6, 0, 12, 12, 12, 12, 13, 12);
    a_in = 32'h11; b_in = 32'h22; ctrl_in = 3'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; res_p = 1; res_s = 1;
    @(posedge clk);
    #1;
    res_p = 2; res_s = 2;
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy", {31'b0, busy}, 32'd0);
    check_val("midrst_done", {31'b0, done}, 32'd0);
    check_val("midrst_flags", {30'b0, spare_active, spare_bad}, 32'd0);
    check_val("midrst_op_a", op_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_sa = 0; m_sb = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("midrst_no_done", {31'b0, done}, 32'd0);
    end
    run_op(5, 7, 3'd0, 0, 12, 12, 12, 12, 12, 12);

    // Randomised ops from a small value pool so mismatches and votes are common.
    for (int i = 0; i < 80; i++) begin
      base = $urandom_range(0, 3);
      for (int k = 0; k < 3; k++) begin
        pr[k] = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : base;
        sr[k] = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : base;
      end
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
             pr[0], pr[1], pr[2], sr[0], sr[1], sr[2]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
